// File: rtl/ov_fifo_reader.sv
// AL422B read-side controller: resets the read pointer after each complete frame,
// clocks out byte pairs and presents them as RGB565 pixels on a valid/ready stream.
module ov_fifo_reader #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int RRST_RCLKS = 2
) (
    input  logic        clk_24MHz,
    input  logic        rst_n,
    input  logic        new_frame,
    output logic        frame_read,
    output logic        fifo_rclk,
    output logic        fifo_rrst_n,
    output logic        fifo_oe_n,
    input  logic [7:0]  fifo_d,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        busy
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int CW = $clog2(RRST_RCLKS + 1);

    typedef enum logic [2:0] {IDLE, RRST, READ_HI, READ_LO, DONE, WAIT_CLR} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    hi_byte;
    logic [CW-1:0] rrst_cnt;
    logic          xfer, hold, x_last, y_last;

    assign xfer   = pix_valid && pix_ready;
    assign hold   = pix_valid && !pix_ready;
    assign x_last = (x == XW'(H_ACTIVE - 1));
    assign y_last = (y == YW'(V_ACTIVE - 1));

    always_ff @(posedge clk_24MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame_read  <= 1'b1;
            fifo_rclk   <= 1'b0;
            fifo_rrst_n <= 1'b1;
            fifo_oe_n   <= 1'b1;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            pix_eof     <= 1'b0;
            busy        <= 1'b0;
            x           <= '0;
            y           <= '0;
            hi_byte     <= '0;
            rrst_cnt    <= '0;
        end else begin
            if (xfer) begin
                pix_valid <= 1'b0;
                if (x_last) begin
                    x <= '0;
                    y <= y_last ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (new_frame) begin
                        state       <= RRST;
                        frame_read  <= 1'b0;
                        fifo_oe_n   <= 1'b0;
                        fifo_rrst_n <= 1'b0;
                        busy        <= 1'b1;
                        rrst_cnt    <= '0;
                    end
                end
                RRST: begin
                    if (!fifo_rclk) begin
                        fifo_rclk <= 1'b1;
                    end else begin
                        fifo_rclk <= 1'b0;
                        if (rrst_cnt == CW'(RRST_RCLKS - 1)) begin
                            fifo_rrst_n <= 1'b1;
                            state       <= READ_HI;
                        end else begin
                            rrst_cnt <= rrst_cnt + 1'b1;
                        end
                    end
                end
                READ_HI: begin
                    // Once the last pixel is pending no further rclk is issued;
                    // its transfer ends the frame.
                    if (fifo_rclk) begin
                        fifo_rclk <= 1'b0;
                        hi_byte   <= fifo_d;
                        state     <= READ_LO;
                    end else if (pix_valid && pix_eof) begin
                        if (pix_ready)
                            state <= DONE;
                    end else if (!hold) begin
                        fifo_rclk <= 1'b1;
                    end
                end
                READ_LO: begin
                    if (fifo_rclk) begin
                        fifo_rclk <= 1'b0;
                        pix_data  <= {hi_byte, fifo_d};
                        pix_valid <= 1'b1;
                        pix_sof   <= (x == '0) && (y == '0);
                        pix_eol   <= x_last;
                        pix_eof   <= x_last && y_last;
                        state     <= READ_HI;
                    end else if (!hold) begin
                        fifo_rclk <= 1'b1;
                    end
                end
                DONE: begin
                    frame_read <= 1'b1;
                    fifo_oe_n  <= 1'b1;
                    state      <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (!new_frame) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov_fifo_reader.sv
// Bench for ov_fifo_reader: AL422B read-port model feeding a pixel scoreboard,
// plus handshake, backpressure, re-arm and mid-frame reset checks.
module tb_ov_fifo_reader;

    localparam int H = 4;
    localparam int V = 3;
    localparam int N = H * V;

    logic        clk_24MHz = 1'b0;
    logic        rst_n     = 1'b1;
    logic        new_frame = 1'b0;
    logic        pix_ready = 1'b1;
    logic [7:0]  fifo_d    = '0;
    logic        frame_read, fifo_rclk, fifo_rrst_n, fifo_oe_n;
    logic [15:0] pix_data;
    logic        pix_valid, pix_sof, pix_eol, pix_eof, busy;

    always #10 clk_24MHz = ~clk_24MHz;

    ov_fifo_reader #(.H_ACTIVE(H), .V_ACTIVE(V), .RRST_RCLKS(2)) dut (
        .clk_24MHz   (clk_24MHz),
        .rst_n       (rst_n),
        .new_frame   (new_frame),
        .frame_read  (frame_read),
        .fifo_rclk   (fifo_rclk),
        .fifo_rrst_n (fifo_rrst_n),
        .fifo_oe_n   (fifo_oe_n),
        .fifo_d      (fifo_d),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .pix_eof     (pix_eof),
        .busy        (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO read port: byte value equals read address; every low byte pushes the
    // expected pixel {hi, lo, sof, eol, eof} into the scoreboard.
    logic [18:0] sb[$];
    int          ptr = 0;
    int          rclk_rises = 0;
    int          rrst_rises = 0;
    logic [7:0]  prev_b = '0;

    always @(posedge fifo_rclk) begin
        logic [7:0] b;
        int idx;
        rclk_rises++;
        if (!fifo_rrst_n) begin
            ptr = 0;
            rrst_rises++;
        end else begin
            b = ptr[7:0];
            fifo_d <= b;
            if (ptr % 2 == 1) begin
                idx = ptr / 2;
                sb.push_back({prev_b, b, idx == 0, (idx % H) == H - 1, idx == N - 1});
            end
            prev_b = b;
            ptr++;
        end
    end

    int cyc = 0;
    int xfers = 0;
    int eofs = 0;
    int last_xfer = 0;
    int bad_gap = 0;

    always @(posedge clk_24MHz) cyc++;

    always @(negedge clk_24MHz) begin
        if (rst_n && pix_valid && pix_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0)
                check("pixel", {pix_data, pix_sof, pix_eol, pix_eof}, sb.pop_front());
            if (xfers > 0 && cyc - last_xfer != 4)
                bad_gap++;
            last_xfer = cyc;
            xfers++;
            if (pix_eof)
                eofs++;
        end
    end

    task automatic clear_counts();
        xfers = 0;
        eofs = 0;
        bad_gap = 0;
        rclk_rises = 0;
        rrst_rises = 0;
    endtask

    task automatic check_reset(input string tag);
        check(tag, {frame_read, fifo_rclk, fifo_rrst_n, fifo_oe_n, pix_valid,
                    pix_sof, pix_eol, pix_eof, busy}, 9'b1_0_1_1_0_0_0_0_0);
        check({tag, "_data"}, pix_data, 0);
    endtask

    // Runs one frame; stall_at >= 0 withholds pix_ready for 10 clk on that pixel.
    task automatic run_frame(input int stall_at);
        int r0;
        logic [15:0] held;
        bit done;
        clear_counts();
        done = 0;
        @(posedge clk_24MHz); #1 new_frame = 1'b1;
        @(posedge clk_24MHz); #1;
        check("frame_read_fall", frame_read, 0);
        check("busy_rise", busy, 1);
        check("rrst_low", fifo_rrst_n, 0);
        for (int t = 0; t < 500 && !done; t++) begin
            @(posedge clk_24MHz); #1;
            if (stall_at >= 0 && pix_valid && pix_ready && xfers == stall_at) begin
                pix_ready = 1'b0;
                held[15:8] = 8'(2 * stall_at);
                held[7:0]  = 8'(2 * stall_at + 1);
                r0 = rclk_rises;
                repeat (10) @(posedge clk_24MHz);
                #1;
                check("stall_rclk", rclk_rises, r0);
                check("stall_data", pix_data, held);
                check("stall_valid", pix_valid, 1);
                pix_ready = 1'b1;
            end
            if (frame_read)
                done = 1;
        end
        check("frame_done", frame_read, 1);
        check("xfers", xfers, N);
        check("eofs", eofs, 1);
        check("rclk_rises", rclk_rises, 2 + 2 * N);
        check("rrst_rises", rrst_rises, 2);
        check("sb_drained", sb.size(), 0);
        check("oe_release", fifo_oe_n, 1);
        if (stall_at < 0)
            check("gap4", bad_gap, 0);
    endtask

    initial begin
        int r0, q0;
        #5 rst_n = 1'b0;
        #1 check_reset("reset_init");
        repeat (2) @(posedge clk_24MHz);
        #1 rst_n = 1'b1;

        run_frame(2);

        // new_frame held high after the frame must not retrigger a read.
        r0 = rclk_rises;
        q0 = rrst_rises;
        repeat (50) @(posedge clk_24MHz);
        #1;
        check("rearm_rclk", rclk_rises, r0);
        check("rearm_rrst", rrst_rises, q0);
        check("rearm_busy", busy, 1);
        new_frame = 1'b0;
        repeat (2) @(posedge clk_24MHz);
        #1 check("idle_busy", busy, 0);

        run_frame(-1);
        new_frame = 1'b0;
        repeat (3) @(posedge clk_24MHz);

        // Reset in the middle of a frame, then a clean restart.
        clear_counts();
        #1 new_frame = 1'b1;
        for (int t = 0; t < 500 && xfers < 5; t++)
            @(posedge clk_24MHz);
        #1 check("mid_reach", xfers, 5);
        rst_n = 1'b0;
        #1 check_reset("reset_mid");
        new_frame = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk_24MHz);
        #1 rst_n = 1'b1;
        @(posedge clk_24MHz);
        #1 check_reset("after_release");

        run_frame(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, miscompares=%0d", miscompares);
        $fatal(1);
    end

endmodule
